// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the RV32I execute stage: pipeline bus layouts,
// opcode and funct3 constants, and the operand forwarding selector.
package ex_stage_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] NOP_INSN = 32'h00000013;

   // The bubble is addi x0,x0,0, so its low seven bits are the OP-IMM opcode.
   localparam logic [6:0] OP_IMM = NOP_INSN[6:0];
   localparam logic [6:0] OP     = 7'h33;
   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] BRANCH = 7'h63;
   localparam logic [6:0] JAL    = 7'h6F;
   localparam logic [6:0] JALR   = 7'h67;
   localparam logic [6:0] LUI    = 7'h37;
   localparam logic [6:0] AUIPC  = 7'h17;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SRL  = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } alu_f3_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
   } id_ex_bus_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] store_data;
   } ex_mem_bus_t;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [XLEN-1:0] wb_value;
   } mem_wb_bus_t;

   typedef struct packed {
      logic takebranch;
      logic dcache_stall;
      logic load_use_stall;
      logic stall;
   } control_signals_t;

   // The MEM-stage producer is younger than the WB one, so it wins when both match.
   function automatic logic [XLEN-1:0] forwardSelect(
      input logic            fromMem,
      input logic            fromWb,
      input logic [XLEN-1:0] memValue,
      input logic [XLEN-1:0] wbValue,
      input logic [XLEN-1:0] regValue
   );
      if (fromMem)
         return memValue;
      else if (fromWb)
         return wbValue;
      else
         return regValue;
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I integer ALU; i_alt selects sub for funct3=000 and sra for 101.
module ex_stage_alu
   import ex_stage_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [2:0]      i_funct3,
   input  logic            i_alt,
   output logic [XLEN-1:0] o_result
);

   logic [4:0] w_shamt;
   logic       w_lessSigned;
   logic       w_lessUnsigned;

   assign w_shamt        = i_b[4:0];
   assign w_lessSigned   = $signed(i_a) < $signed(i_b);
   assign w_lessUnsigned = i_a < i_b;

   always_comb begin
      o_result = '0;
      case (alu_f3_e'(i_funct3))
         F3_ADD:  o_result = i_alt ? (i_a - i_b) : (i_a + i_b);
         F3_SLL:  o_result = i_a << w_shamt;
         F3_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lessSigned};
         F3_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lessUnsigned};
         F3_XOR:  o_result = i_a ^ i_b;
         F3_SRL:  o_result = i_alt ? XLEN'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
         F3_OR:   o_result = i_a | i_b;
         F3_AND:  o_result = i_a & i_b;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU and address/link computation driving the
// EX/MEM bus combinationally, plus a registered count of forwarding cycles.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  id_ex_bus_t       id_ex_bus_in,
   input  ex_mem_bus_t      ex_mem_bus_in,
   input  mem_wb_bus_t      mem_wb_bus_in,
   input  logic             bypassAfromMEM,
   input  logic             bypassBfromMEM,
   input  logic             bypassAfromALUinWB,
   input  logic             bypassBfromALUinWB,
   input  logic             bypassAfromLDinWB,
   input  logic             bypassBfromLDinWB,
   input  control_signals_t ctrl_signals_in,
   output ex_mem_bus_t      ex_mem_bus_out,
   output logic [XLEN-1:0]  bypass_count
);

   logic [XLEN-1:0] w_fwdRs1;
   logic [XLEN-1:0] w_fwdRs2;
   logic [XLEN-1:0] w_opB;
   logic [XLEN-1:0] w_aluResult;
   logic            w_alt;
   logic            w_anyBypass;
   logic            w_countEnable;
   logic            w_unused_inputs;
   logic [XLEN-1:0] r_bypassCount;

   assign w_fwdRs1 = forwardSelect(bypassAfromMEM,
                                   bypassAfromALUinWB | bypassAfromLDinWB,
                                   ex_mem_bus_in.alu_result,
                                   mem_wb_bus_in.wb_value,
                                   id_ex_bus_in.rs1_val);

   assign w_fwdRs2 = forwardSelect(bypassBfromMEM,
                                   bypassBfromALUinWB | bypassBfromLDinWB,
                                   ex_mem_bus_in.alu_result,
                                   mem_wb_bus_in.wb_value,
                                   id_ex_bus_in.rs2_val);

   // Register-register forms take rs2; every other format feeds the immediate.
   always_comb begin
      w_opB = id_ex_bus_in.imm;
      if (id_ex_bus_in.opcode == OP || id_ex_bus_in.opcode == BRANCH)
         w_opB = w_fwdRs2;
   end

   // funct7[5] means sub only for register adds; for addi it is just immediate bits.
   always_comb begin
      if (id_ex_bus_in.funct3 == F3_ADD)
         w_alt = (id_ex_bus_in.opcode == OP) && id_ex_bus_in.funct7[5];
      else
         w_alt = id_ex_bus_in.funct7[5];
   end

   ex_stage_alu u_alu (
      .i_a      (w_fwdRs1),
      .i_b      (w_opB),
      .i_funct3 (id_ex_bus_in.funct3),
      .i_alt    (w_alt),
      .o_result (w_aluResult)
   );

   // Unknown opcodes and branches leave the stage as writes to x0 with a zero result.
   always_comb begin
      ex_mem_bus_out.pc         = id_ex_bus_in.pc;
      ex_mem_bus_out.opcode     = id_ex_bus_in.opcode;
      ex_mem_bus_out.funct3     = id_ex_bus_in.funct3;
      ex_mem_bus_out.rd         = id_ex_bus_in.rd;
      ex_mem_bus_out.store_data = w_fwdRs2;
      ex_mem_bus_out.alu_result = '0;
      case (id_ex_bus_in.opcode)
         OP, OP_IMM:  ex_mem_bus_out.alu_result = w_aluResult;
         LOAD, STORE: ex_mem_bus_out.alu_result = w_fwdRs1 + id_ex_bus_in.imm;
         LUI:         ex_mem_bus_out.alu_result = id_ex_bus_in.imm;
         AUIPC:       ex_mem_bus_out.alu_result = id_ex_bus_in.pc + id_ex_bus_in.imm;
         JAL, JALR:   ex_mem_bus_out.alu_result = id_ex_bus_in.pc + 32'd4;
         default:     ex_mem_bus_out.rd         = '0;
      endcase
   end

   assign w_anyBypass = bypassAfromMEM | bypassBfromMEM |
                        bypassAfromALUinWB | bypassBfromALUinWB |
                        bypassAfromLDinWB | bypassBfromLDinWB;

   // Stores and branches consume forwarded values without writing a register.
   assign w_countEnable = w_anyBypass && !ctrl_signals_in.stall &&
                          ((id_ex_bus_in.rd != 5'd0) ||
                           (id_ex_bus_in.opcode == STORE) ||
                           (id_ex_bus_in.opcode == BRANCH));

   always_ff @(posedge clock) begin
      if (reset)
         r_bypassCount <= '0;
      else if (w_countEnable)
         r_bypassCount <= r_bypassCount + 1'b1;
   end

   assign bypass_count = r_bypassCount;

   assign w_unused_inputs = ^{ctrl_signals_in.takebranch, ctrl_signals_in.dcache_stall,
                              ctrl_signals_in.load_use_stall, id_ex_bus_in.rs1,
                              id_ex_bus_in.rs2, ex_mem_bus_in.pc, ex_mem_bus_in.opcode,
                              ex_mem_bus_in.funct3, ex_mem_bus_in.rd,
                              ex_mem_bus_in.store_data, mem_wb_bus_in.opcode,
                              mem_wb_bus_in.rd};

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: combinational results checked #1 after
// stimulus, bypass_count checked #1 after each rising edge.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic             clock;
   logic             reset;
   id_ex_bus_t       idEx;
   ex_mem_bus_t      exMemIn;
   mem_wb_bus_t      memWbIn;
   logic             aMem, bMem, aAlu, bAlu, aLd, bLd;
   control_signals_t ctrl;
   ex_mem_bus_t      exMemOut;
   logic [31:0]      bypassCount;

   int compared   = 0;
   int mismatched = 0;
   int expCnt     = 0;

   ex_stage dut (
      .clock              (clock),
      .reset              (reset),
      .id_ex_bus_in       (idEx),
      .ex_mem_bus_in      (exMemIn),
      .mem_wb_bus_in      (memWbIn),
      .bypassAfromMEM     (aMem),
      .bypassBfromMEM     (bMem),
      .bypassAfromALUinWB (aAlu),
      .bypassBfromALUinWB (bAlu),
      .bypassAfromLDinWB  (aLd),
      .bypassBfromLDinWB  (bLd),
      .ctrl_signals_in    (ctrl),
      .ex_mem_bus_out     (exMemOut),
      .bypass_count       (bypassCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // flags = {aMem, aAlu, aLd, bMem, bAlu, bLd}
   task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd,
                                input logic [31:0] pc, input logic [31:0] rs1v,
                                input logic [31:0] rs2v, input logic [31:0] imm,
                                input logic [5:0] flags);
      idEx.opcode  = opc;
      idEx.funct3  = f3;
      idEx.funct7  = f7;
      idEx.rd      = rd;
      idEx.rs1     = 5'd1;
      idEx.rs2     = 5'd2;
      idEx.pc      = pc;
      idEx.rs1_val = rs1v;
      idEx.rs2_val = rs2v;
      idEx.imm     = imm;
      {aMem, aAlu, aLd, bMem, bAlu, bLd} = flags;
      #1;
   endtask

   task automatic tickCount(input string tag);
      @(posedge clock);
      #1;
      checkOutput(tag, bypassCount, expCnt);
   endtask

   initial begin
      reset   = 1'b1;
      ctrl    = '0;
      exMemIn = '0;
      memWbIn = '0;
      applyStimulus(7'h00, 3'd0, 7'h00, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 6'b0);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_count", bypassCount, 32'd0);
      checkOutput("bubble_rd", {27'd0, exMemOut.rd}, 32'd0);
      reset = 1'b0;

      applyStimulus(OP, 3'd0, 7'h00, 5'd3, 32'h0, 32'd5, 32'd7, 32'h0, 6'b0);
      checkOutput("add_result", exMemOut.alu_result, 32'd12);
      checkOutput("add_rd", {27'd0, exMemOut.rd}, 32'd3);
      tickCount("count_no_flags");

      exMemIn.alu_result = 32'd100;
      memWbIn.wb_value   = 32'd200;
      applyStimulus(OP, 3'd0, 7'h00, 5'd3, 32'h0, 32'd5, 32'd7, 32'h0, 6'b110000);
      checkOutput("add_mem_priority", exMemOut.alu_result, 32'd107);
      expCnt = 1;
      tickCount("count_after_fwd");

      memWbIn.wb_value = 32'hDEADBEEF;
      applyStimulus(STORE, 3'd2, 7'h7F, 5'd0, 32'h0, 32'h1000, 32'h55, 32'hFFFFFFFC, 6'b000001);
      checkOutput("sw_addr", exMemOut.alu_result, 32'h00000FFC);
      checkOutput("sw_data", exMemOut.store_data, 32'hDEADBEEF);
      expCnt = 2;
      tickCount("count_store");

      applyStimulus(OP, 3'd0, 7'h20, 5'd5, 32'h0, 32'h80000000, 32'd1, 32'h0, 6'b0);
      checkOutput("sub_wrap", exMemOut.alu_result, 32'h7FFFFFFF);
      applyStimulus(OP, 3'd5, 7'h20, 5'd5, 32'h0, 32'h80000000, 32'd4, 32'h0, 6'b0);
      checkOutput("sra", exMemOut.alu_result, 32'hF8000000);
      applyStimulus(OP, 3'd5, 7'h00, 5'd5, 32'h0, 32'h80000000, 32'd4, 32'h0, 6'b0);
      checkOutput("srl", exMemOut.alu_result, 32'h08000000);
      applyStimulus(OP_IMM, 3'd5, 7'h20, 5'd5, 32'h0, 32'h80000000, 32'd0, 32'h404, 6'b0);
      checkOutput("srai", exMemOut.alu_result, 32'hF8000000);
      applyStimulus(OP, 3'd3, 7'h00, 5'd5, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, 6'b0);
      checkOutput("sltu", exMemOut.alu_result, 32'd1);
      applyStimulus(OP, 3'd2, 7'h00, 5'd5, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, 6'b0);
      checkOutput("slt", exMemOut.alu_result, 32'd0);
      applyStimulus(OP_IMM, 3'd0, 7'h7E, 5'd5, 32'h0, 32'd10, 32'd0, 32'hFFFFFC00, 6'b0);
      checkOutput("addi_neg", exMemOut.alu_result, 32'hFFFFFC0A);
      applyStimulus(OP, 3'd4, 7'h00, 5'd5, 32'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0, 6'b0);
      checkOutput("xor", exMemOut.alu_result, 32'h00000FF0);
      applyStimulus(OP, 3'd6, 7'h00, 5'd5, 32'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0, 6'b0);
      checkOutput("or", exMemOut.alu_result, 32'h0000FFF0);
      applyStimulus(OP, 3'd7, 7'h00, 5'd5, 32'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0, 6'b0);
      checkOutput("and", exMemOut.alu_result, 32'h0000F000);
      applyStimulus(OP, 3'd1, 7'h00, 5'd5, 32'h0, 32'd1, 32'h21, 32'h0, 6'b0);
      checkOutput("sll_shamt5", exMemOut.alu_result, 32'd2);

      applyStimulus(JAL, 3'd0, 7'h00, 5'd1, 32'h40, 32'd0, 32'd0, 32'h100, 6'b0);
      checkOutput("jal_link", exMemOut.alu_result, 32'h44);
      checkOutput("jal_pc", exMemOut.pc, 32'h40);
      applyStimulus(JALR, 3'd0, 7'h00, 5'd1, 32'h80, 32'h9, 32'd0, 32'h8, 6'b0);
      checkOutput("jalr_link", exMemOut.alu_result, 32'h84);
      applyStimulus(LUI, 3'd0, 7'h00, 5'd7, 32'h0, 32'd0, 32'd0, 32'h12345000, 6'b0);
      checkOutput("lui", exMemOut.alu_result, 32'h12345000);
      applyStimulus(AUIPC, 3'd0, 7'h00, 5'd7, 32'h100, 32'd0, 32'd0, 32'h1000, 6'b0);
      checkOutput("auipc", exMemOut.alu_result, 32'h1100);
      applyStimulus(LOAD, 3'd2, 7'h00, 5'd7, 32'h0, 32'h2000, 32'd0, 32'd8, 6'b0);
      checkOutput("load_addr", exMemOut.alu_result, 32'h2008);

      applyStimulus(BRANCH, 3'd0, 7'h00, 5'd5, 32'h40, 32'd3, 32'd3, 32'h10, 6'b100000);
      checkOutput("beq_result", exMemOut.alu_result, 32'd0);
      checkOutput("beq_rd", {27'd0, exMemOut.rd}, 32'd0);
      expCnt = 3;
      tickCount("count_branch");

      memWbIn.wb_value = 32'd50;
      applyStimulus(OP, 3'd0, 7'h00, 5'd6, 32'h0, 32'd3, 32'd9, 32'h0, 6'b000010);
      checkOutput("add_b_from_wb", exMemOut.alu_result, 32'd53);
      expCnt = 4;
      tickCount("count_wb_fwd");

      applyStimulus(OP, 3'd0, 7'h00, 5'd0, 32'h0, 32'd5, 32'd7, 32'h0, 6'b100000);
      checkOutput("add_rd0_result", exMemOut.alu_result, 32'd107);
      tickCount("count_rd0_hold");

      applyStimulus(7'h7F, 3'd0, 7'h00, 5'd9, 32'h0, 32'd5, 32'd7, 32'h0, 6'b0);
      checkOutput("illegal_rd", {27'd0, exMemOut.rd}, 32'd0);
      checkOutput("illegal_result", exMemOut.alu_result, 32'd0);

      ctrl.stall = 1'b1;
      applyStimulus(OP, 3'd0, 7'h00, 5'd3, 32'h0, 32'd5, 32'd7, 32'h0, 6'b100000);
      checkOutput("stall_result", exMemOut.alu_result, 32'd107);
      tickCount("count_stall_hold");

      ctrl.stall = 1'b0;
      reset      = 1'b1;
      expCnt     = 0;
      tickCount("count_reset_priority");
      reset  = 1'b0;
      expCnt = 1;
      tickCount("count_resume");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
